ngy_sram_arbiter: RTL and testbench

Arbitrates the single external asynchronous SRAM (17-bit address, 16-bit data) between two requesters in the `clk_74a` domain:
- a video read port that feeds the pixel driver;
- a game-logic write port used by the snake/grid update engine.

It sequences the SRAM control strobes with programmable wait states and owns the tristate data bus. It sits between the game top level and the SRAM chip pins.

---
 rtl/ngy_sram_arbiter.sv | 176 +++++++++++++++++
 tb/tb_ngy_sram_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ngy_sram_arbiter.sv
// Shares one async 16-bit SRAM between a video read port and a game-logic write port.
// Reads take RD_WAIT cycles plus an idle cycle; writes take 2+WE_PULSE+WR_RECOVER cycles.
module ngy_sram_arbiter #(
  parameter int ADDR_W       = 17,
  parameter int RD_WAIT      = 3,
  parameter int WE_PULSE     = 3,
  parameter int WR_RECOVER   = 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk_74a,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic [15:0]       vid_rdata,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [15:0]       wr_data,
  input  logic [1:0]        wr_mask,
  output logic              wr_ready,
  output logic              busy,
  output logic [16:0]       sram_chip_addr,
  inout  wire  [15:0]       sram_chip_data,
  output logic              sram_chip_oe_n,
  output logic              sram_chip_we_n,
  output logic              sram_chip_ub_n,
  output logic              sram_chip_lb_n
);

  localparam int CMAX_RW = (RD_WAIT > WE_PULSE) ? RD_WAIT : WE_PULSE;
  localparam int CMAX    = (CMAX_RW > WR_RECOVER) ? CMAX_RW : WR_RECOVER;
  localparam int CNT_W   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int STK_W   = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [STK_W-1:0] streak_q, streak_d;
  logic [16:0]      addr_q;
  logic [15:0]      wdata_q;
  logic [15:0]      rdata_q;
  logic             drive_q;
  logic             ack_q, rdy_q, busy_q;
  logic             oe_n_q, we_n_q, ub_n_q, lb_n_q;
  logic             rd_win, wr_win;

  // A pending write blocks further reads only once the read streak has saturated.
  assign rd_win = (state_q == S_IDLE) && vid_req &&
                  !(wr_valid && (streak_q == STK_W'(STARVE_LIMIT)));
  assign wr_win = (state_q == S_IDLE) && !rd_win && wr_valid;

  always_comb begin
    streak_d = streak_q;
    if (!wr_valid) begin
      streak_d = '0;
    end else if (rd_win) begin
      if (streak_q != STK_W'(STARVE_LIMIT)) streak_d = streak_q + 1'b1;
    end else if (wr_win) begin
      streak_d = '0;
    end
  end

  always_ff @(posedge clk_74a) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      streak_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      drive_q  <= 1'b0;
      ack_q    <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      ub_n_q   <= 1'b1;
      lb_n_q   <= 1'b1;
    end else begin
      ack_q    <= 1'b0;
      rdy_q    <= 1'b0;
      streak_q <= streak_d;
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (rd_win) begin
            state_q <= S_READ;
            addr_q  <= 17'(vid_addr);
            oe_n_q  <= 1'b0;
            ub_n_q  <= 1'b0;
            lb_n_q  <= 1'b0;
            busy_q  <= 1'b1;
          end else if (wr_win) begin
            state_q <= S_WR_SETUP;
            addr_q  <= 17'(wr_addr);
            wdata_q <= wr_data;
            ub_n_q  <= ~wr_mask[1];
            lb_n_q  <= ~wr_mask[0];
            drive_q <= 1'b1;
            rdy_q   <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_READ: begin
          if (cnt_q == CNT_W'(RD_WAIT - 1)) begin
            state_q <= S_IDLE;
            rdata_q <= sram_chip_data;
            ack_q   <= 1'b1;
            oe_n_q  <= 1'b1;
            ub_n_q  <= 1'b1;
            lb_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_WR_SETUP: begin
          state_q <= S_WR_PULSE;
          we_n_q  <= 1'b0;
          cnt_q   <= '0;
        end
        S_WR_PULSE: begin
          if (cnt_q == CNT_W'(WE_PULSE - 1)) begin
            state_q <= S_WR_HOLD;
            we_n_q  <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_WR_HOLD: begin
          if (cnt_q == CNT_W'(WR_RECOVER - 1)) begin
            state_q <= S_IDLE;
            drive_q <= 1'b0;
            ub_n_q  <= 1'b1;
            lb_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          drive_q <= 1'b0;
          oe_n_q  <= 1'b1;
          we_n_q  <= 1'b1;
          ub_n_q  <= 1'b1;
          lb_n_q  <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // drive_q is only ever set from IDLE, so it never overlaps a low oe_n.
  assign sram_chip_data = drive_q ? wdata_q : 16'hzzzz;
  assign sram_chip_addr = addr_q;
  assign sram_chip_oe_n = oe_n_q;
  assign sram_chip_we_n = we_n_q;
  assign sram_chip_ub_n = ub_n_q;
  assign sram_chip_lb_n = lb_n_q;
  assign vid_ack        = ack_q;
  assign vid_rdata      = rdata_q;
  assign wr_ready       = rdy_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_ngy_sram_arbiter.sv
// Bench for ngy_sram_arbiter: SRAM model, transaction-level expectation model, directed and random traffic.
module tb_ngy_sram_arbiter;
  localparam int RD_WAIT      = 3;
  localparam int WE_PULSE     = 3;
  localparam int WR_RECOVER   = 1;
  localparam int STARVE_LIMIT = 8;

  logic        clk = 1'b0;
  logic        reset, vid_req, wr_valid;
  logic [16:0] vid_addr, wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  wr_mask;
  logic        vid_ack, wr_ready, busy;
  logic [15:0] vid_rdata;
  logic [16:0] sram_addr;
  wire  [15:0] sram_data;
  logic        oe_n, we_n, ub_n, lb_n;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ngy_sram_arbiter #(
    .ADDR_W(17), .RD_WAIT(RD_WAIT), .WE_PULSE(WE_PULSE),
    .WR_RECOVER(WR_RECOVER), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk_74a(clk), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
    .wr_ready(wr_ready), .busy(busy),
    .sram_chip_addr(sram_addr), .sram_chip_data(sram_data),
    .sram_chip_oe_n(oe_n), .sram_chip_we_n(we_n),
    .sram_chip_ub_n(ub_n), .sram_chip_lb_n(lb_n)
  );

  // Asynchronous SRAM: 2K words, drives the bus while oe_n is low, byte-masked write while we_n is low.
  logic [15:0] mem [0:2047];
  assign sram_data = !oe_n ? mem[sram_addr[10:0]] : 16'hzzzz;

  always @(negedge clk) begin
    if (!we_n) begin
      if (!ub_n) mem[sram_addr[10:0]][15:8] = sram_data[15:8];
      if (!lb_n) mem[sram_addr[10:0]][7:0]  = sram_data[7:0];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: one outstanding transfer, expected pins derived from cycle offset since grant.
  int          cyc = 0, gedge = 0, k = 0, kind = 0, streak = 0;
  logic        model_on = 1'b0, m_rd, m_wr;
  logic [16:0] m_addr;
  logic [15:0] m_data, e_rdata;
  logic [1:0]  m_mask;
  logic        e_oe, e_we, e_ub, e_lb, e_drv, e_ack, e_rdy, e_busy;

  always @(posedge clk) begin
    cyc++;
    e_ack = 1'b0;
    e_rdy = 1'b0;
    if (reset) begin
      kind = 0; streak = 0; m_addr = '0; e_rdata = '0; model_on = 1'b1;
    end else if (model_on) begin
      if (kind == 0) begin
        m_rd = vid_req && !(wr_valid && streak == STARVE_LIMIT);
        m_wr = !m_rd && wr_valid;
        if (m_rd) begin
          kind = 1; gedge = cyc; m_addr = vid_addr;
        end else if (m_wr) begin
          kind = 2; gedge = cyc; m_addr = wr_addr; m_data = wr_data; m_mask = wr_mask;
        end
        if (!wr_valid) streak = 0;
        else if (m_rd) streak = (streak < STARVE_LIMIT) ? streak + 1 : streak;
        else if (m_wr) streak = 0;
      end else if (!wr_valid) begin
        streak = 0;
      end
    end
    k = cyc - gedge;
    e_oe = 1'b1; e_we = 1'b1; e_ub = 1'b1; e_lb = 1'b1; e_drv = 1'b0; e_busy = 1'b0;
    if (kind == 1 && k == RD_WAIT) begin
      e_ack = 1'b1; e_rdata = mem[m_addr[10:0]]; kind = 0;
    end
    if (kind == 2 && k == WE_PULSE + WR_RECOVER + 1) kind = 0;
    if (kind == 1) begin
      e_oe = 1'b0; e_ub = 1'b0; e_lb = 1'b0; e_busy = 1'b1;
    end
    if (kind == 2) begin
      e_busy = 1'b1; e_drv = 1'b1; e_ub = ~m_mask[1]; e_lb = ~m_mask[0];
      e_rdy = (k == 0);
      e_we = !(k >= 1 && k <= WE_PULSE);
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("oe_n", 32'(oe_n), 32'(e_oe));
      chk("we_n", 32'(we_n), 32'(e_we));
      chk("ub_n", 32'(ub_n), 32'(e_ub));
      chk("lb_n", 32'(lb_n), 32'(e_lb));
      chk("vid_ack", 32'(vid_ack), 32'(e_ack));
      chk("wr_ready", 32'(wr_ready), 32'(e_rdy));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("addr", 32'(sram_addr), 32'(m_addr));
      chk("vid_rdata", 32'(vid_rdata), 32'(e_rdata));
      if (e_drv) chk("bus_data", 32'(sram_data), 32'(m_data));
      chk("oe_we_overlap", 32'(oe_n | we_n), 32'd1);
    end
  end

  int n, oe_low, rdy_cnt, we_cnt, acks, acks_before, after;
  logic got, done, ub_p, lb_p;

  task automatic do_read(input logic [16:0] a);
    vid_addr = a; vid_req = 1'b1; n = 0; oe_low = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (!oe_n) oe_low++;
      if (vid_ack) begin got = 1'b1; vid_req = 1'b0; end
    end
    vid_req = 1'b0;
  endtask

  task automatic do_write(input logic [16:0] a, input logic [15:0] d, input logic [1:0] m);
    wr_addr = a; wr_data = d; wr_mask = m; wr_valid = 1'b1;
    n = 0; rdy_cnt = 0; we_cnt = 0; done = 1'b0; ub_p = 1'b1; lb_p = 1'b1;
    while (!done && n < 30) begin
      @(negedge clk);
      n++;
      if (wr_ready) begin rdy_cnt++; wr_valid = 1'b0; end
      if (!we_n) begin we_cnt++; ub_p = ub_n; lb_p = lb_n; end
      if (rdy_cnt > 0 && !busy) done = 1'b1;
    end
    wr_valid = 1'b0;
    chk("wr_done", 32'(done), 32'd1);
  endtask

  initial begin
    reset = 1'b1; vid_req = 1'b0; wr_valid = 1'b0;
    vid_addr = '0; wr_addr = '0; wr_data = '0; wr_mask = '0;
    for (int i = 0; i < 2048; i++) mem[i] = 16'(i * 37) ^ 16'h5A5A;
    repeat (3) @(negedge clk);
    chk("rst_oe_n", 32'(oe_n), 32'd1);
    chk("rst_we_n", 32'(we_n), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_addr", 32'(sram_addr), 32'd0);
    chk("rst_rdata", 32'(vid_rdata), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    mem[11'h123] = 16'hBEEF;
    do_read(17'h00123);
    chk("rd_ack_latency", 32'(n), 32'd4);
    chk("rd_data", 32'(vid_rdata), 32'h0000BEEF);
    chk("rd_oe_cycles", 32'(oe_low), 32'd3);
    repeat (2) @(negedge clk);

    do_write(17'h004B0, 16'h0001, 2'b11);
    @(negedge clk);
    chk("wr_ready_pulses", 32'(rdy_cnt), 32'd1);
    chk("wr_we_cycles", 32'(we_cnt), 32'd3);
    chk("wr_word_full", 32'(mem[11'h4B0]), 32'h00000001);

    mem[11'h02A] = 16'hFFFF;
    do_write(17'h0002A, 16'hA5C3, 2'b01);
    @(negedge clk);
    chk("wr_word_lo", 32'(mem[11'h02A]), 32'h0000FFC3);
    chk("wr_lo_ub_n", 32'(ub_p), 32'd1);
    chk("wr_lo_lb_n", 32'(lb_p), 32'd0);

    mem[11'h030] = 16'h7777;
    do_write(17'h00030, 16'h1234, 2'b00);
    @(negedge clk);
    chk("wr_nomask_word", 32'(mem[11'h030]), 32'h00007777);
    chk("wr_nomask_we_cycles", 32'(we_cnt), 32'd3);

    // Continuous reads against a pending write: the write must get in after the streak limit.
    vid_addr = 17'h00100; vid_req = 1'b1;
    wr_addr = 17'h00200; wr_data = 16'hCAFE; wr_mask = 2'b11; wr_valid = 1'b1;
    acks = 0; acks_before = -1; after = 0; n = 0;
    while (n < 200 && !(acks_before >= 0 && after >= 2)) begin
      @(negedge clk);
      n++;
      if (vid_ack) begin
        acks++;
        vid_addr = vid_addr + 17'd1;
        if (acks_before >= 0) after++;
      end
      if (wr_ready) begin acks_before = acks; wr_valid = 1'b0; end
    end
    vid_req = 1'b0; wr_valid = 1'b0;
    chk("starve_reads_before_write", 32'(acks_before), 32'd8);
    chk("reads_resume", 32'(after), 32'd2);
    repeat (4) @(negedge clk);
    chk("starve_write_word", 32'(mem[11'h200]), 32'h0000CAFE);

    // Reset during the second write-pulse cycle.
    wr_addr = 17'h00300; wr_data = 16'h1111; wr_mask = 2'b11; wr_valid = 1'b1;
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (wr_ready) begin got = 1'b1; wr_valid = 1'b0; end
    end
    wr_valid = 1'b0;
    chk("abort_wr_granted", 32'(got), 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("abort_in_pulse", 32'(we_n), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_we_n", 32'(we_n), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rdy", 32'(wr_ready), 32'd0);
    chk("abort_ack", 32'(vid_ack), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    mem[11'h456] = 16'h5EED;
    do_read(17'h00456);
    chk("post_abort_latency", 32'(n), 32'd4);
    chk("post_abort_data", 32'(vid_rdata), 32'h00005EED);

    // Mixed random traffic obeying the level handshakes.
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      if (vid_req) begin
        if (vid_ack) begin
          vid_req = 1'($urandom_range(0, 1));
          vid_addr = 17'($urandom_range(0, 2047));
        end
      end else if ($urandom_range(0, 3) == 0) begin
        vid_req = 1'b1;
        vid_addr = 17'($urandom_range(0, 2047));
      end
      if (wr_valid) begin
        if (wr_ready) begin
          wr_valid = 1'($urandom_range(0, 1));
          wr_addr = 17'($urandom_range(0, 2047));
          wr_data = 16'($urandom);
          wr_mask = 2'($urandom_range(0, 3));
        end
      end else if ($urandom_range(0, 4) == 0) begin
        wr_valid = 1'b1;
        wr_addr = 17'($urandom_range(0, 2047));
        wr_data = 16'($urandom);
        wr_mask = 2'($urandom_range(0, 3));
      end
    end
    n = 0;
    while ((vid_req || wr_valid) && n < 20) begin
      @(negedge clk);
      n++;
      if (vid_ack) vid_req = 1'b0;
      if (wr_ready) wr_valid = 1'b0;
    end
    vid_req = 1'b0; wr_valid = 1'b0;
    repeat (12) @(negedge clk);
    chk("drain_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
